bg_fetcher: RTL and testbench
=============================

BG_FETCHER -- requirements
Module: bg_fetcher

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  one-cycle pulse; begin background fetch for the current line.
REQ-004 stop  in  1  one-cycle pulse; abort fetching and return to IDLE.
REQ-005 win_start  in  1  one-cycle pulse; switch to window fetching mid-line.
REQ-006 ly, scx, scy, window_line  in  8 each  line, scroll and window line counters.
REQ-007 bg_map_sel, win_map_sel, tile_data_sel  in  1 each  LCDC bits 3, 6, 4.
REQ-008 vram_rd  out  1  VRAM read strobe.
REQ-009 vram_addr  out  13  VRAM byte offset; read data returns one cycle after the strobe.
REQ-010 vram_rdata  in  8  VRAM read data.
REQ-011 fifo_push  out  1  push strobe to the pixel FIFO.
REQ-012 fifo_px  out  ppu_pixel_t  pushed pixel; color field = 2-bit index, all other fields '0.
REQ-013 fifo_count  in  5  current FIFO occupancy.
REQ-014 fifo_flush  out  1  one-cycle FIFO flush request.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, TILE, DLO, DHI, PUSH; each of TILE/DLO/DHI lasts exactly 2 cycles.
REQ-017 Fetch-state cycle 1: vram_rd=1 with that state's address; cycle 2: vram_rd=0, vram_rdata registered (tile_no, lo, hi respectively).
REQ-018 Transitions: IDLE -start-> TILE -> DLO -> DHI -> PUSH; after the 8th push PUSH -> TILE, fetch_x increments.
REQ-019 BG map address = (bg_map_sel ? 0x1C00 : 0x1800) + {ly+scy}[7:3]*32 + ((scx[7:3]+fetch_x) mod 32); all sums 8-bit wrap.
REQ-020 BG line = (ly+scy)[2:0]; window row = window_line[7:3], window column = fetch_x mod 32, window line = window_line[2:0], window map base from win_map_sel.
REQ-021 Tile-data address (lo) = tile_data_sel ? tile_no*16 + line*2 : 0x1000 + signed(tile_no)*16 + line*2; hi address = lo address + 1.
REQ-022 PUSH waits while fifo_count > 8; once fifo_count <= 8, pushes 8 pixels on 8 consecutive cycles with no further occupancy check.
REQ-023 Pixel i (i=0 first) color = {hi[7-i], lo[7-i]}.
REQ-024 fetch_x is 5 bits, cleared on start and win_start, wraps 31 -> 0.
REQ-025 Priority of simultaneous events: reset > stop > start > win_start.
REQ-026 start in any state: abort the current tile without pushing its pixels, clear fetch_x, BG mode, enter TILE next cycle.
REQ-027 stop in any state: enter IDLE next cycle; no push in that cycle or later.
REQ-028 win_start in a non-IDLE state: fifo_flush=1 for exactly one cycle, window mode, fetch_x=0, enter TILE next cycle; ignored in IDLE.
REQ-029 Earliest first push: 6 cycles after TILE is entered.

Reset
REQ-030 On reset: state=IDLE, fetch_x=0, BG mode, and vram_rd, vram_addr, fifo_push, fifo_px, fifo_flush, busy all 0.
REQ-031 Reset asserted mid-fetch discards all registered tile data.

Configuration
REQ-032 Macro PPU_FETCH_WINDOW_EN defined: window mode per REQ-020/REQ-028 is included.
REQ-033 PPU_FETCH_WINDOW_EN undefined: win_start, window_line and win_map_sel are ignored, fifo_flush is tied to 0, and only BG mode exists.

Verification
REQ-034 Reset asserted -> vram_rd=0, fifo_push=0, busy=0, fifo_flush=0.
REQ-035 start; ly=scx=scy=0, bg_map_sel=0, tile_data_sel=1; rdata 0x05, 0xF0, 0xAA -> addresses 0x1800, 0x0050, 0x0051; pushed colors 3,1,3,1,2,0,2,0; next map address 0x1801.
REQ-036 tile_data_sel=0, ly=3, tile_no=0x80 -> lo address 0x0806, hi address 0x0807.
REQ-037 fifo_count=9 on entry to PUSH -> fifo_push stays 0; count drops to 8 -> 8 pushes on consecutive cycles.
REQ-038 scx=0xF8 -> first map address 0x181F; second map address 0x1800 (column wrap).
REQ-039 PPU_FETCH_WINDOW_EN defined; win_start during DLO with win_map_sel=1, window_line=10 -> fifo_flush pulse of 1 cycle, next map address 0x1C20, no pixels from the aborted tile.

Source files
------------

// File: rtl/bg_fetcher.sv
// bg_fetcher -- background/window tile fetcher feeding the pixel FIFO.
//
// Walks one 8-pixel tile at a time: map read (TILE), low bit-plane read
// (DLO), high bit-plane read (DHI), then eight pushes into the pixel FIFO
// (PUSH). Each fetch state takes two cycles: a strobe cycle and a data
// cycle, matching the one-cycle VRAM read latency.
//
// Optional feature macro: PPU_FETCH_WINDOW_EN
//   defined   -> win_start switches to window fetching mid-line and
//                pulses fifo_flush.
//   undefined -> background fetching only; win_start, window_line and
//                win_map_sel are ignored and fifo_flush is held low.

package ppu_pkg;
    typedef struct packed {
        logic [1:0] color;
        logic [2:0] palette;
        logic       bg_priority;
        logic       is_sprite;
    } ppu_pixel_t;
endpackage

module bg_fetcher (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                win_start,
    input  logic [7:0]          ly,
    input  logic [7:0]          scx,
    input  logic [7:0]          scy,
    input  logic [7:0]          window_line,
    input  logic                bg_map_sel,
    input  logic                win_map_sel,
    input  logic                tile_data_sel,
    output logic                vram_rd,
    output logic [12:0]         vram_addr,
    input  logic [7:0]          vram_rdata,
    output logic                fifo_push,
    output ppu_pkg::ppu_pixel_t fifo_px,
    input  logic [4:0]          fifo_count,
    output logic                fifo_flush,
    output logic                busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TILE = 3'd1,
        ST_DLO  = 3'd2,
        ST_DHI  = 3'd3,
        ST_PUSH = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_phase;       // 0 = strobe cycle, 1 = data cycle
    logic [4:0]          r_fetch_x;     // tile column counter, wraps 31 -> 0
    logic [7:0]          r_tile_no;
    logic [7:0]          r_lo;
    logic [3:0]          r_pix_cnt;     // pixels already issued for this tile
    logic [7:0]          r_hi;
    logic                r_vram_rd;
    logic [12:0]         r_vram_addr;
    logic                r_fifo_push;
    ppu_pkg::ppu_pixel_t r_fifo_px;

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    logic [7:0]  w_bg_y;            // ly + scy, 8-bit wrap
    logic [4:0]  w_fx_inc;          // fetch_x of the next tile
    logic [4:0]  w_bg_col_start;
    logic [4:0]  w_bg_col_inc;
    logic [12:0] w_bg_base;
    logic [12:0] w_bg_addr_start;   // first map address of a BG run
    logic [12:0] w_bg_addr_next;    // BG map address of the following tile
    logic [12:0] w_win_addr_start;  // first map address of a window run
    logic [12:0] w_next_map_addr;   // map address after the 8th push
    logic        w_win_mode;
    logic        w_win_start_ev;    // win_start that is actually honoured
    logic [2:0]  w_line;            // pixel row inside the tile
    logic [7:0]  w_tile_src;
    logic [12:0] w_line_x2;
    logic [12:0] w_tile_lo_addr;
    logic [12:0] w_tile_hi_addr;
    logic        w_fifo_room;
    logic [2:0]  w_pix_sel;
    logic [1:0]  w_pix_color;

    assign w_bg_y          = ly + scy;
    assign w_fx_inc        = r_fetch_x + 5'd1;
    assign w_bg_col_start  = scx[7:3];
    assign w_bg_col_inc    = scx[7:3] + w_fx_inc;
    assign w_bg_base       = bg_map_sel ? 13'h1C00 : 13'h1800;
    assign w_bg_addr_start = w_bg_base + {3'b000, w_bg_y[7:3], w_bg_col_start};
    assign w_bg_addr_next  = w_bg_base + {3'b000, w_bg_y[7:3], w_bg_col_inc};

    // Fine-scroll bits only matter to the pixel pipeline, not the fetcher.
    logic w_unused_scx;
    assign w_unused_scx = &{1'b0, scx[2:0]};

`ifdef PPU_FETCH_WINDOW_EN
    logic        r_win;             // 1 = fetching window tiles
    logic        r_fifo_flush;
    logic [12:0] w_win_base;
    logic [12:0] w_win_addr_next;

    assign w_win_base       = win_map_sel ? 13'h1C00 : 13'h1800;
    assign w_win_addr_start = w_win_base + {3'b000, window_line[7:3], 5'd0};
    assign w_win_addr_next  = w_win_base + {3'b000, window_line[7:3], w_fx_inc};
    assign w_win_mode       = r_win;
    assign w_win_start_ev   = win_start && (r_state != ST_IDLE);
    assign w_next_map_addr  = r_win ? w_win_addr_next : w_bg_addr_next;
    assign w_line           = r_win ? window_line[2:0] : w_bg_y[2:0];

    // Window mode flag and the one-cycle FIFO flush that accompanies a switch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win        <= 1'b0;
            r_fifo_flush <= 1'b0;
        end else begin
            r_fifo_flush <= 1'b0;
            if (stop) begin
                r_win <= r_win;
            end else if (start) begin
                r_win <= 1'b0;
            end else if (w_win_start_ev) begin
                r_win        <= 1'b1;
                r_fifo_flush <= 1'b1;
            end
        end
    end

    assign fifo_flush = r_fifo_flush;
`else
    // Background-only build: window inputs have no effect.
    logic w_unused_win;
    assign w_unused_win     = &{1'b0, win_start, window_line, win_map_sel};
    assign w_win_addr_start = 13'h0000;
    assign w_win_mode       = 1'b0;
    assign w_win_start_ev   = 1'b0;
    assign w_next_map_addr  = w_bg_addr_next;
    assign w_line           = w_bg_y[2:0];
    assign fifo_flush       = 1'b0;
`endif

    // The tile number arrives on vram_rdata at the end of TILE; afterwards
    // it is taken from the register.
    assign w_tile_src = (r_state == ST_TILE) ? vram_rdata : r_tile_no;
    assign w_line_x2  = {9'd0, w_line, 1'b0};

    // Unsigned addressing from 0x0000, or signed tile number around 0x1000.
    assign w_tile_lo_addr = tile_data_sel
                          ? ({1'b0, w_tile_src, 4'b0000} + w_line_x2)
                          : (13'h1000 + {w_tile_src[7], w_tile_src, 4'b0000} + w_line_x2);
    assign w_tile_hi_addr = w_tile_lo_addr + 13'd1;

    assign w_fifo_room = (fifo_count <= 5'd8);

    // Leftmost pixel comes from bit 7 of both planes.
    assign w_pix_sel   = 3'd7 - r_pix_cnt[2:0];
    assign w_pix_color = {r_hi[w_pix_sel], r_lo[w_pix_sel]};

    function automatic ppu_pkg::ppu_pixel_t make_px(input logic [1:0] color);
        ppu_pkg::ppu_pixel_t px;
        px       = '0;
        px.color = color;
        return px;
    endfunction

    // ------------------------------------------------------------------
    // Fetch state machine with registered VRAM and FIFO outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= 1'b0;
            r_fetch_x   <= 5'd0;
            r_tile_no   <= 8'h00;
            r_lo        <= 8'h00;
            r_hi        <= 8'h00;
            r_pix_cnt   <= 4'd0;
            r_vram_rd   <= 1'b0;
            r_vram_addr <= 13'h0000;
            r_fifo_push <= 1'b0;
            r_fifo_px   <= '0;
        end else begin
            r_vram_rd   <= 1'b0;
            r_fifo_push <= 1'b0;

            if (stop) begin
                r_state   <= ST_IDLE;
                r_phase   <= 1'b0;
                r_pix_cnt <= 4'd0;
            end else if (start) begin
                // Restart the line in BG mode; the current tile is dropped.
                r_state     <= ST_TILE;
                r_phase     <= 1'b0;
                r_pix_cnt   <= 4'd0;
                r_fetch_x   <= 5'd0;
                r_vram_rd   <= 1'b1;
                r_vram_addr <= w_bg_addr_start;
            end else if (w_win_start_ev) begin
                // Switch to the window; the current tile is dropped.
                r_state     <= ST_TILE;
                r_phase     <= 1'b0;
                r_pix_cnt   <= 4'd0;
                r_fetch_x   <= 5'd0;
                r_vram_rd   <= 1'b1;
                r_vram_addr <= w_win_addr_start;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_phase <= 1'b0;
                    end

                    ST_TILE: begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase     <= 1'b0;
                            r_tile_no   <= vram_rdata;
                            r_state     <= ST_DLO;
                            r_vram_rd   <= 1'b1;
                            r_vram_addr <= w_tile_lo_addr;
                        end
                    end

                    ST_DLO: begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase     <= 1'b0;
                            r_lo        <= vram_rdata;
                            r_state     <= ST_DHI;
                            r_vram_rd   <= 1'b1;
                            r_vram_addr <= w_tile_hi_addr;
                        end
                    end

                    ST_DHI: begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            // High plane is on vram_rdata now, so the first
                            // pixel can go out on the first PUSH cycle.
                            r_phase <= 1'b0;
                            r_hi    <= vram_rdata;
                            r_state <= ST_PUSH;
                            if (w_fifo_room) begin
                                r_fifo_push <= 1'b1;
                                r_fifo_px   <= make_px({vram_rdata[7], r_lo[7]});
                                r_pix_cnt   <= 4'd1;
                            end else begin
                                r_pix_cnt   <= 4'd0;
                            end
                        end
                    end

                    ST_PUSH: begin
                        if (r_pix_cnt == 4'd8) begin
                            // Eighth pixel is on the bus this cycle.
                            r_state     <= ST_TILE;
                            r_phase     <= 1'b0;
                            r_pix_cnt   <= 4'd0;
                            r_fetch_x   <= w_fx_inc;
                            r_vram_rd   <= 1'b1;
                            r_vram_addr <= w_next_map_addr;
                        end else if ((r_pix_cnt != 4'd0) || w_fifo_room) begin
                            // Occupancy only gates the first pixel of a tile.
                            r_fifo_push <= 1'b1;
                            r_fifo_px   <= make_px(w_pix_color);
                            r_pix_cnt   <= r_pix_cnt + 4'd1;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_phase <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Mode flag only steers address selection; keep it referenced in both builds.
    logic w_unused_mode;
    assign w_unused_mode = &{1'b0, w_win_mode};

    assign vram_rd   = r_vram_rd;
    assign vram_addr = r_vram_addr;
    assign fifo_push = r_fifo_push;
    assign fifo_px   = r_fifo_px;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bg_fetcher.sv
// tb_bg_fetcher -- directed bench for bg_fetcher with a VRAM model and an
// address/pixel scoreboard. Build with +define+PPU_FETCH_WINDOW_EN to
// exercise window fetching.
module tb_bg_fetcher;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        win_start;
    logic [7:0]  ly;
    logic [7:0]  scx;
    logic [7:0]  scy;
    logic [7:0]  window_line;
    logic        bg_map_sel;
    logic        win_map_sel;
    logic        tile_data_sel;
    logic        vram_rd;
    logic [12:0] vram_addr;
    logic [7:0]  vram_rdata;
    logic        fifo_push;
    ppu_pixel_t  fifo_px;
    logic [4:0]  fifo_count;
    logic        fifo_flush;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  vmem [0:8191];
    logic [12:0] addr_q [$];
    logic [1:0]  pix_q  [$];
    logic [12:0] exp_a;
    ppu_pixel_t  exp_px;

    bg_fetcher dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .win_start     (win_start),
        .ly            (ly),
        .scx           (scx),
        .scy           (scy),
        .window_line   (window_line),
        .bg_map_sel    (bg_map_sel),
        .win_map_sel   (win_map_sel),
        .tile_data_sel (tile_data_sel),
        .vram_rd       (vram_rd),
        .vram_addr     (vram_addr),
        .vram_rdata    (vram_rdata),
        .fifo_push     (fifo_push),
        .fifo_px       (fifo_px),
        .fifo_count    (fifo_count),
        .fifo_flush    (fifo_flush),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // VRAM model: data for a strobe appears during the following cycle.
    always @(negedge clk) begin
        if (vram_rd === 1'b1) vram_rdata = vmem[vram_addr];
    end

    // Scoreboard monitor: one line per VRAM read and per FIFO push.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (vram_rd === 1'b1) begin
                $display("rd   addr=%04h", vram_addr);
                if (addr_q.size() > 0) begin
                    exp_a = addr_q.pop_front();
                    total++;
                    assert (vram_addr === exp_a) else begin
                        bad++;
                        $error("FAIL vram_addr got=%04h exp=%04h", vram_addr, exp_a);
                    end
                end
            end
            if (fifo_push === 1'b1) begin
                $display("push color=%0d", fifo_px.color);
                if (pix_q.size() > 0) begin
                    exp_px       = '0;
                    exp_px.color = pix_q.pop_front();
                    total++;
                    assert (fifo_px === exp_px) else begin
                        bad++;
                        $error("FAIL fifo_px got=%h exp=%h", fifo_px, exp_px);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected pixels of one tile: pixel i = {hi[7-i], lo[7-i]}.
    task automatic push_pix(input logic [7:0] lo, input logic [7:0] hi);
        for (int i = 0; i < 8; i++) pix_q.push_back({hi[7-i], lo[7-i]});
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((addr_q.size() != 0 || pix_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, addr_q.size() + pix_q.size(), 0);
        addr_q.delete();
        pix_q.delete();
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  n;
        int  run;
        logic sawp;

        reset = 1'b1; start = 1'b0; stop = 1'b0; win_start = 1'b0;
        ly = 8'h00; scx = 8'h00; scy = 8'h00; window_line = 8'h00;
        bg_map_sel = 1'b0; win_map_sel = 1'b0; tile_data_sel = 1'b1;
        fifo_count = 5'd0; vram_rdata = 8'h00;
        for (int i = 0; i < 8192; i++) vmem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_vram_rd", vram_rd, 0);
        check("rst_vram_addr", vram_addr, 0);
        check("rst_fifo_push", fifo_push, 0);
        check("rst_fifo_px", fifo_px, 0);
        check("rst_fifo_flush", fifo_flush, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Basic BG tile, first-push latency, next map address
        vmem[13'h1800] = 8'h05; vmem[13'h0050] = 8'hF0; vmem[13'h0051] = 8'hAA;
        addr_q.push_back(13'h1800); addr_q.push_back(13'h0050);
        addr_q.push_back(13'h0051); addr_q.push_back(13'h1801);
        push_pix(8'hF0, 8'hAA);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_run", busy, 1);
        n = 0;
        while (fifo_push !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("first_push_lat", n, 6);
        wait_drain("basic");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        sawp = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_push === 1'b1 || vram_rd === 1'b1) sawp = 1'b1;
        end
        check("stop_quiet", sawp, 0);

        // Signed tile data addressing plus FIFO-full hold
        tile_data_sel = 1'b0; ly = 8'd3; bg_map_sel = 1'b1; fifo_count = 5'd9;
        vmem[13'h1C00] = 8'h80; vmem[13'h0806] = 8'h3C; vmem[13'h0807] = 8'h0F;
        addr_q.push_back(13'h1C00); addr_q.push_back(13'h0806); addr_q.push_back(13'h0807);
        push_pix(8'h3C, 8'h0F);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sawp = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_push === 1'b1) sawp = 1'b1;
        end
        check("full_hold", sawp, 0);
        check("signed_addrs_seen", addr_q.size(), 0);
        fifo_count = 5'd8;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (fifo_push === 1'b1) break;
        end
        check("resume_lat", n, 1);
        run = 1;
        while (run < 12) begin
            @(negedge clk);
            if (fifo_push !== 1'b1) break;
            run++;
        end
        check("push_run", run, 8);
        wait_drain("full");
        do_stop();
        fifo_count = 5'd0; tile_data_sel = 1'b1; ly = 8'h00; bg_map_sel = 1'b0;

        // Column wrap and ly+scy wrap
        ly = 8'h05; scy = 8'hFE; scx = 8'hF8;
        vmem[13'h181F] = 8'h01; vmem[13'h0016] = 8'h81; vmem[13'h0017] = 8'h42;
        addr_q.push_back(13'h181F); addr_q.push_back(13'h0016);
        addr_q.push_back(13'h0017); addr_q.push_back(13'h1800);
        push_pix(8'h81, 8'h42);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("wrap");
        do_stop();
        ly = 8'h00; scy = 8'h00; scx = 8'h00;

        // Priority: stop beats start
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("stop_over_start_busy", busy, 0);
        check("stop_over_start_rd", vram_rd, 0);

        // Restart mid-tile; start also beats a simultaneous win_start
        win_map_sel = 1'b1; window_line = 8'd10;
        vmem[13'h1C20] = 8'h02; vmem[13'h0024] = 8'hC3; vmem[13'h0025] = 8'h5A;
        addr_q.push_back(13'h1800); addr_q.push_back(13'h0050);
        addr_q.push_back(13'h1800); addr_q.push_back(13'h0050); addr_q.push_back(13'h0051);
        push_pix(8'hF0, 8'hAA);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; win_start = 1'b1;
        @(negedge clk);
        start = 1'b0; win_start = 1'b0;
        check("start_over_win_flush", fifo_flush, 0);
        n = 0;
        while (fifo_push !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("restart_lat", n, 6);
        wait_drain("restart");
        do_stop();

        // win_start ignored in IDLE
        win_start = 1'b1;
        @(negedge clk);
        win_start = 1'b0;
        check("idle_win_busy", busy, 0);
        check("idle_win_flush", fifo_flush, 0);

        // win_start during DLO
`ifdef PPU_FETCH_WINDOW_EN
        addr_q.push_back(13'h1800); addr_q.push_back(13'h0050);
        addr_q.push_back(13'h1C20); addr_q.push_back(13'h0024); addr_q.push_back(13'h0025);
        push_pix(8'hC3, 8'h5A);
`else
        addr_q.push_back(13'h1800); addr_q.push_back(13'h0050); addr_q.push_back(13'h0051);
        push_pix(8'hF0, 8'hAA);
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        win_start = 1'b1;
        @(negedge clk);
        win_start = 1'b0;
`ifdef PPU_FETCH_WINDOW_EN
        check("win_flush_pulse", fifo_flush, 1);
`else
        check("win_flush_off", fifo_flush, 0);
`endif
        @(negedge clk);
        check("win_flush_after", fifo_flush, 0);
        wait_drain("window");
        do_stop();

        // Asynchronous reset mid-fetch, then a clean fetch afterwards
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_vram_rd", vram_rd, 0);
        check("arst_vram_addr", vram_addr, 0);
        check("arst_fifo_push", fifo_push, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        addr_q.push_back(13'h1800); addr_q.push_back(13'h0050);
        addr_q.push_back(13'h0051); addr_q.push_back(13'h1801);
        push_pix(8'hF0, 8'hAA);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("post_reset");
        do_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
